mem_port_master: RTL

- Initiator for one port of the 16-bit synchronous two-port data/instruction memory.
- Accepts read/write requests from a processor-side client over a valid/ready handshake and buffers them in a request FIFO.
- Drives the memory's address, write-data, Write and Read strobes one operation per cycle, and captures the one-cycle-latency read data into a response FIFO.
- Returns responses to the client in order with valid/ready backpressure. One instance per memory port (fetch side, data side).

---
 rtl/mem_port_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_port_master.sv
// Queued initiator for one port of a synchronous two-port memory: request FIFO -> issue -> response FIFO.
// Optional feature macro MEM_PORT_MASTER_WRITE_ACK_EN: writes take a credit and return an ack response.
module mem_port_master #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_is_write,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_W,
    output logic              mem_Write,
    output logic              mem_Read,
    input  logic [DATA_W-1:0] mem_R,
    output logic              busy
);
    localparam int QA = $clog2(REQ_DEPTH);
    localparam int SA = $clog2(RSP_DEPTH);
    localparam int CW = SA + 2;
    localparam int QW = 1 + ADDR_W + DATA_W;
    localparam int SW = 1 + DATA_W;
`ifdef MEM_PORT_MASTER_WRITE_ACK_EN
    localparam logic WACK = 1'b1;
`else
    localparam logic WACK = 1'b0;
`endif

    logic [QW-1:0]     req_mem_q [REQ_DEPTH];
    logic [QA:0]       req_wp_q, req_wp_d, req_rp_q, req_rp_d;
    logic [SW-1:0]     rsp_mem_q [RSP_DEPTH];
    logic [SA:0]       rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_w_q, mem_w_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              s2_vld_q, s2_vld_d;
    logic              s2_we_q, s2_we_d;
    logic [DATA_W-1:0] s2_wdata_q, s2_wdata_d;

    logic              req_empty_s, req_full_s, rsp_empty_s;
    logic              req_push_s, rsp_push_s, rsp_pop_s;
    logic              head_we_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_wdata_s;
    logic [SA:0]       rsp_cnt_s;
    logic [CW-1:0]     used_s;
    logic              credit_ok_s, issue_rd_s, issue_wr_s, issue_s, s1_vld_s;
    logic [SW-1:0]     rsp_head_s, rsp_in_s;

    // Credits count response slots already filled plus ops still travelling through the memory.
    always_comb begin
        req_empty_s  = (req_wp_q == req_rp_q);
        req_full_s   = (req_wp_q[QA] != req_rp_q[QA]) && (req_wp_q[QA-1:0] == req_rp_q[QA-1:0]);
        rsp_empty_s  = (rsp_wp_q == rsp_rp_q);
        {head_we_s, head_addr_s, head_wdata_s} = req_mem_q[req_rp_q[QA-1:0]];
        s1_vld_s     = mem_read_q | (WACK & mem_write_q);
        rsp_cnt_s    = rsp_wp_q - rsp_rp_q;
        used_s       = CW'(rsp_cnt_s) + CW'(s1_vld_s) + CW'(s2_vld_q);
        credit_ok_s  = (used_s < CW'(RSP_DEPTH));
        issue_rd_s   = !req_empty_s && !head_we_s && credit_ok_s;
        issue_wr_s   = !req_empty_s && head_we_s && (!WACK || credit_ok_s);
        issue_s      = issue_rd_s | issue_wr_s;
        req_push_s   = req_valid && !req_full_s;
        rsp_pop_s    = !rsp_empty_s && rsp_ready;
        rsp_push_s   = s2_vld_q;
        rsp_in_s     = {s2_we_q, (s2_we_q ? s2_wdata_q : mem_R)};
        rsp_head_s   = rsp_mem_q[rsp_rp_q[SA-1:0]];
    end

    always_comb begin
        mem_a_d     = mem_a_q;
        mem_w_d     = mem_w_q;
        if (issue_s) begin
            mem_a_d = head_addr_s;
            mem_w_d = head_wdata_s;
        end else begin
            mem_a_d = mem_a_q;
            mem_w_d = mem_w_q;
        end
        mem_read_d  = issue_rd_s;
        mem_write_d = issue_wr_s;
        s2_vld_d    = s1_vld_s;
        s2_we_d     = WACK & mem_write_q;
        s2_wdata_d  = mem_w_q;
        req_wp_d    = req_push_s ? (req_wp_q + {{QA{1'b0}}, 1'b1}) : req_wp_q;
        req_rp_d    = issue_s    ? (req_rp_q + {{QA{1'b0}}, 1'b1}) : req_rp_q;
        rsp_wp_d    = rsp_push_s ? (rsp_wp_q + {{SA{1'b0}}, 1'b1}) : rsp_wp_q;
        rsp_rp_d    = rsp_pop_s  ? (rsp_rp_q + {{SA{1'b0}}, 1'b1}) : rsp_rp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_wp_q    <= '0;
            req_rp_q    <= '0;
            rsp_wp_q    <= '0;
            rsp_rp_q    <= '0;
            mem_a_q     <= '0;
            mem_w_q     <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_we_q     <= 1'b0;
            s2_wdata_q  <= '0;
        end else begin
            req_wp_q    <= req_wp_d;
            req_rp_q    <= req_rp_d;
            rsp_wp_q    <= rsp_wp_d;
            rsp_rp_q    <= rsp_rp_d;
            mem_a_q     <= mem_a_d;
            mem_w_q     <= mem_w_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            s2_vld_q    <= s2_vld_d;
            s2_we_q     <= s2_we_d;
            s2_wdata_q  <= s2_wdata_d;
        end
    end

    // FIFO storage needs no reset: entries are only observed between the pointers.
    always_ff @(posedge clk) begin
        if (req_push_s) begin
            req_mem_q[req_wp_q[QA-1:0]] <= {req_we, req_addr, req_wdata};
        end
        if (rsp_push_s) begin
            rsp_mem_q[rsp_wp_q[SA-1:0]] <= rsp_in_s;
        end
    end

    assign req_ready    = !req_full_s;
    assign rsp_valid    = !rsp_empty_s;
    assign rsp_rdata    = rsp_empty_s ? {DATA_W{1'b0}} : rsp_head_s[DATA_W-1:0];
    assign rsp_is_write = !rsp_empty_s & rsp_head_s[DATA_W];
    assign mem_A        = mem_a_q;
    assign mem_W        = mem_w_q;
    assign mem_Write    = mem_write_q;
    assign mem_Read     = mem_read_q;
    assign busy         = !req_empty_s | s1_vld_s | s2_vld_q | !rsp_empty_s;

endmodule
